i2s_tx_fifo_param: RTL and testbench

Parametrised next-generation I2S transmit buffer: a DEPTH-entry sample FIFO feeding a serialiser that shifts out 16/24/32-bit slots.
- Supports stereo or mono, Philips I2S or left-justified framing, and master or slave word-select.
- Single clock domain: the bit clock arrives as a one-cycle enable strobe (bit_en) generated in the wclk domain by the clock-divider block.
- Adds level reporting, sticky underrun/overflow flags and frame-aligned configuration capture.

---
 rtl/i2s_tx_fifo_param_if.sv | 26 ++
 rtl/i2s_tx_fifo_param.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_i2s_tx_fifo_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_fifo_param_if.sv
// rtl/i2s_tx_fifo_param_if.sv - sample write port and status of the I2S transmit FIFO
interface i2s_tx_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              wen;
  logic [DATA_W-1:0] din;
  logic              clr_flags;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              underrun;

  modport master (
    output wen, din, clr_flags,
    input  full, empty, level, overflow, underrun
  );

  modport slave (
    input  wen, din, clr_flags,
    output full, empty, level, overflow, underrun
  );
endinterface

// File: rtl/i2s_tx_fifo_param.sv
// rtl/i2s_tx_fifo_param.sv - I2S transmit FIFO and slot serialiser; optional I2S_TX_ALMOST_EMPTY_EN adds almost_empty
module i2s_tx_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                wclk,
  input  logic                rst,
  i2s_tx_fifo_param_if.slave  wr,
  input  logic                tx_en,
  input  logic                bit_en,
  input  logic [1:0]          frame_size,
  input  logic                stereo,
  input  logic                standard,
  input  logic                master,
  input  logic                ws_in,
  output logic                ws_out,
  output logic                ws_oe,
  output logic                sd_out,
  output logic                busy
`ifdef I2S_TX_ALMOST_EMPTY_EN
  ,
  output logic                almost_empty
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              und_q, und_d;
  logic              push, pop, und_evt;
  logic              full_w, empty_w;
  logic [31:0]       head;

  // Serialiser state
  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       sh_q, sh_d;
  logic              sd_q, sd_d;
  logic              ws_q, ws_d;
  logic              ws_oe_q, ws_oe_d;
  logic              lead_q, lead_d;
  logic              short_q, short_d;
  logic [1:0]        fs_q, fs_d;
  logic              st_q, st_d;
  logic              std_q, std_d;
  logic              mst_q, mst_d;
  logic [31:0]       left_q, left_d;
  logic              ws_prev_q, ws_prev_d;

  // Per-strobe decisions
  logic              ws_fall, ws_rise;
  logic              cap, do_left, do_right, do_shift, go_idle;
  logic [1:0]        e_fs;
  logic              e_st;
  logic [31:0]       word;

  // Last bit index of a slot: 16, 24 or 32 bits (code 11 behaves as 32)
  function automatic logic [4:0] slot_last(input logic [1:0] fs);
    case (fs)
      2'b00:   slot_last = 5'd15;
      2'b01:   slot_last = 5'd23;
      default: slot_last = 5'd31;
    endcase
  endfunction

  // Move the right-justified sample so its MSB sits in bit 31
  function automatic logic [31:0] align(input logic [31:0] w, input logic [1:0] fs);
    case (fs)
      2'b00:   align = {w[15:0], 16'h0000};
      2'b01:   align = {w[23:0], 8'h00};
      default: align = w;
    endcase
  endfunction

  assign full_w  = (level_q == LW'(DEPTH));
  assign empty_w = (level_q == '0);
  assign head    = mem_q[rd_ptr_q][31:0];
  assign ws_fall = !ws_in && ws_prev_q;
  assign ws_rise = ws_in && !ws_prev_q;

  // FIFO pointers, level and sticky flags; a new event beats a same-cycle clear
  always_comb begin
    push     = wr.wen && !full_w;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    ovf_d    = ovf_q;
    und_d    = und_q;
    if (wr.clr_flags) begin
      ovf_d = 1'b0;
      und_d = 1'b0;
    end
    if (wr.wen && full_w) ovf_d = 1'b1;
    if (und_evt)          und_d = 1'b1;
  end

  // Serialiser next state: every change is gated by the bit strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    sd_d      = sd_q;
    ws_d      = ws_q;
    ws_oe_d   = ws_oe_q;
    lead_d    = lead_q;
    short_d   = short_q;
    fs_d      = fs_q;
    st_d      = st_q;
    std_d     = std_q;
    mst_d     = mst_q;
    left_d    = left_q;
    ws_prev_d = bit_en ? ws_in : ws_prev_q;
    pop       = 1'b0;
    und_evt   = 1'b0;
    cap       = 1'b0;
    do_left   = 1'b0;
    do_right  = 1'b0;
    do_shift  = 1'b0;
    go_idle   = 1'b0;
    e_fs      = fs_q;
    e_st      = st_q;
    word      = '0;

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (tx_en) begin
            if (master) begin
              cap = 1'b1;
              if (standard) begin
                do_left = 1'b1;
              end else begin
                // I2S from idle: one silent bit so the first MSB trails the WS edge
                state_d = LEFT;
                lead_d  = 1'b1;
                sd_d    = 1'b0;
                ws_d    = 1'b0;
              end
            end else if (ws_fall) begin
              cap     = 1'b1;
              do_left = 1'b1;
            end
          end
        end
        default: begin
          if (!mst_q) begin
            // Slave: slots are started by WS edges; after the LSB the
            // emptied shift register pads zeros until the next edge
            if (ws_fall) begin
              if (tx_en && !master) begin
                cap     = 1'b1;
                do_left = 1'b1;
              end else begin
                go_idle = 1'b1;
              end
            end else if (ws_rise && (state_q == LEFT)) begin
              do_right = 1'b1;
            end else if ((cnt_q == 5'd0) && (state_q == RIGHT) && !tx_en) begin
              go_idle = 1'b1;
            end else begin
              do_shift = 1'b1;
            end
          end else if (lead_q) begin
            do_left = 1'b1;
          end else if (cnt_q != 5'd0) begin
            do_shift = 1'b1;
            // I2S moves WS together with the LSB of the current slot
            if (!std_q && (cnt_q == 5'd1)) ws_d = (state_q == LEFT);
          end else if (state_q == LEFT) begin
            do_right = 1'b1;
          end else if (tx_en && master) begin
            cap     = 1'b1;
            do_left = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
      endcase
    end

    if (cap) begin
      fs_d    = frame_size;
      st_d    = stereo;
      std_d   = master & standard;
      mst_d   = master;
      ws_oe_d = master;
      e_fs    = frame_size;
      e_st    = stereo;
    end

    if (do_shift) begin
      sd_d = sh_q[31];
      sh_d = {sh_q[30:0], 1'b0};
      if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
    end

    if (do_left) begin
      state_d = LEFT;
      lead_d  = 1'b0;
      cnt_d   = slot_last(e_fs);
      ws_d    = 1'b0;
      // The whole frame's data must already be queued, otherwise send silence
      if (e_st ? (level_q >= LW'(2)) : !empty_w) begin
        pop     = 1'b1;
        short_d = 1'b0;
        left_d  = head;
        word    = align(head, e_fs);
      end else begin
        short_d = 1'b1;
        und_evt = 1'b1;
      end
      sd_d = word[31];
      sh_d = {word[30:0], 1'b0};
    end

    if (do_right) begin
      state_d = RIGHT;
      cnt_d   = slot_last(fs_q);
      ws_d    = mst_q;
      if (!short_q) begin
        if (st_q) begin
          pop  = 1'b1;
          word = align(head, fs_q);
        end else begin
          word = align(left_q, fs_q);
        end
      end
      sd_d = word[31];
      sh_d = {word[30:0], 1'b0};
    end

    if (go_idle) begin
      state_d = IDLE;
      lead_d  = 1'b0;
      cnt_d   = 5'd0;
      sh_d    = '0;
      sd_d    = 1'b0;
      ws_d    = 1'b0;
      ws_oe_d = 1'b0;
    end
  end

  // Sample storage; contents need no reset because level gates every read
  always_ff @(posedge wclk) begin
    if (push) mem_q[wr_ptr_q] <= wr.din;
  end

  // State registers with synchronous reset
  always_ff @(posedge wclk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      und_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      sh_q      <= '0;
      sd_q      <= 1'b0;
      ws_q      <= 1'b0;
      ws_oe_q   <= 1'b0;
      lead_q    <= 1'b0;
      short_q   <= 1'b0;
      fs_q      <= 2'b00;
      st_q      <= 1'b0;
      std_q     <= 1'b0;
      mst_q     <= 1'b0;
      left_q    <= '0;
      ws_prev_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      und_q     <= und_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      sd_q      <= sd_d;
      ws_q      <= ws_d;
      ws_oe_q   <= ws_oe_d;
      lead_q    <= lead_d;
      short_q   <= short_d;
      fs_q      <= fs_d;
      st_q      <= st_d;
      std_q     <= std_d;
      mst_q     <= mst_d;
      left_q    <= left_d;
      ws_prev_q <= ws_prev_d;
    end
  end

  assign wr.full     = full_w;
  assign wr.empty    = empty_w;
  assign wr.level    = level_q;
  assign wr.overflow = ovf_q;
  assign wr.underrun = und_q;
  assign sd_out      = sd_q;
  assign ws_out      = ws_q;
  assign ws_oe       = ws_oe_q;
  assign busy        = (state_q != IDLE);

`ifdef I2S_TX_ALMOST_EMPTY_EN
  assign almost_empty = (level_q <= LW'(AE_THRESH));
`endif

endmodule

// File: tb/tb_i2s_tx_fifo_param.sv
// tb/tb_i2s_tx_fifo_param.sv - directed self-checking bench for i2s_tx_fifo_param
module tb_i2s_tx_fifo_param;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic       wclk = 1'b0;
  logic       rst;
  logic       tx_en, bit_en, stereo, standard, master, ws_in;
  logic [1:0] frame_size;
  logic       ws_out, ws_oe, sd_out, busy;
`ifdef I2S_TX_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        s_sd, s_ws;
  logic [63:0] v_sd, v_ws;
  logic        oe_acc;

  always #5 wclk = ~wclk;

  i2s_tx_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) wr_if ();

  i2s_tx_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .wclk       (wclk),
    .rst        (rst),
    .wr         (wr_if),
    .tx_en      (tx_en),
    .bit_en     (bit_en),
    .frame_size (frame_size),
    .stereo     (stereo),
    .standard   (standard),
    .master     (master),
    .ws_in      (ws_in),
    .ws_out     (ws_out),
    .ws_oe      (ws_oe),
    .sd_out     (sd_out),
    .busy       (busy)
`ifdef I2S_TX_ALMOST_EMPTY_EN
    ,
    .almost_empty (almost_empty)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    rst = 1'b1;
    @(negedge wclk);
    @(negedge wclk);
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    @(negedge wclk);
    wr_if.wen = 1'b1;
    wr_if.din = d;
    @(negedge wclk);
    wr_if.wen = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge wclk);
    wr_if.clr_flags = 1'b1;
    @(negedge wclk);
    wr_if.clr_flags = 1'b0;
  endtask

  // One bit strobe (optionally with a write in the same cycle), then sample
  task automatic strobe(input logic w, input logic [31:0] d);
    @(negedge wclk);
    bit_en    = 1'b1;
    wr_if.wen = w;
    wr_if.din = d;
    @(negedge wclk);
    bit_en    = 1'b0;
    wr_if.wen = 1'b0;
    s_sd = sd_out;
    s_ws = ws_out;
    v_sd = {v_sd[62:0], s_sd};
    v_ws = {v_ws[62:0], s_ws};
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; bit_en = 1'b0; frame_size = 2'b00;
    stereo = 1'b1; standard = 1'b1; master = 1'b1; ws_in = 1'b0;
    wr_if.wen = 1'b0; wr_if.din = '0; wr_if.clr_flags = 1'b0;
    v_sd = '0; v_ws = '0; oe_acc = 1'b0;
    do_reset();
    check("reset_state", {wr_if.full, wr_if.empty, wr_if.level, wr_if.overflow, wr_if.underrun,
                          sd_out, ws_out, ws_oe, busy}, 12'h400);
`ifdef I2S_TX_ALMOST_EMPTY_EN
    check("reset_almost_empty", almost_empty, 1'b1);
`endif

    // Stereo 16-bit master left-justified
    write_word(32'hA5A5);
    write_word(32'h5A5A);
    check("lj_level_pre", wr_if.level, 2);
    frame_size = 2'b00; stereo = 1'b1; standard = 1'b1; master = 1'b1; tx_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      strobe(1'b0, 32'h0);
      if (i == 0) begin
        tx_en = 1'b0;
        check("lj_level_left", wr_if.level, 1);
        check("lj_ws_oe", ws_oe, 1'b1);
      end
      if (i == 16) check("lj_level_right", wr_if.level, 0);
    end
    check("lj_sd", v_sd[31:0], 32'hA5A55A5A);
    check("lj_ws", v_ws[31:0], 32'h0000FFFF);
    strobe(1'b0, 32'h0);
    check("lj_idle", {busy, ws_oe, sd_out, ws_out}, 4'h0);
    check("lj_underrun", wr_if.underrun, 1'b0);

    // Same words, Philips I2S: lead-in bit and early WS edges
    write_word(32'hA5A5);
    write_word(32'h5A5A);
    standard = 1'b0; tx_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      strobe(1'b0, 32'h0);
      if (i == 0) begin
        tx_en = 1'b0;
        check("i2s_lead_level", wr_if.level, 2);
      end
    end
    check("i2s_sd", v_sd[32:0], {1'b0, 16'hA5A5, 16'h5A5A});
    check("i2s_ws", v_ws[32:0], {16'h0000, 16'hFFFF, 1'b0});
    strobe(1'b0, 32'h0);
    check("i2s_idle", busy, 1'b0);

    // Overflow on a ninth write, clear precedence
    for (int k = 0; k < 7; k++) write_word(32'(k + 1));
    check("ovf_not_full_7", wr_if.full, 1'b0);
    write_word(32'h8);
    check("ovf_full_8", {wr_if.full, wr_if.level}, {1'b1, 4'd8});
`ifdef I2S_TX_ALMOST_EMPTY_EN
    check("full_almost_empty", almost_empty, 1'b0);
`endif
    write_word(32'h9);
    check("ovf_dropped", {wr_if.overflow, wr_if.level}, {1'b1, 4'd8});
    @(negedge wclk);
    wr_if.wen = 1'b1; wr_if.clr_flags = 1'b1;
    @(negedge wclk);
    wr_if.wen = 1'b0; wr_if.clr_flags = 1'b0;
    check("ovf_event_beats_clr", wr_if.overflow, 1'b1);
    pulse_clr();
    check("ovf_cleared", wr_if.overflow, 1'b0);

    // Mono 24-bit, then an underrun frame of silence
    do_reset();
    write_word(32'h800001);
    frame_size = 2'b01; stereo = 1'b0; standard = 1'b1; master = 1'b1; tx_en = 1'b1;
    for (int i = 0; i < 48; i++) strobe(1'b0, 32'h0);
    check("mono_sd", v_sd[47:0], 48'h800001800001);
    check("mono_ws", v_ws[47:0], 48'h000000FFFFFF);
    check("mono_no_underrun", {wr_if.underrun, wr_if.level}, 5'h0);
    for (int i = 0; i < 48; i++) begin
      strobe(1'b0, 32'h0);
      if (i == 0) begin
        tx_en = 1'b0;
        check("mono_underrun_set", wr_if.underrun, 1'b1);
      end
    end
    check("mono_zero_sd", v_sd[47:0], 48'h0);
    check("mono_zero_ws", v_ws[47:0], 48'h000000FFFFFF);
    strobe(1'b0, 32'h0);
    check("mono_idle", busy, 1'b0);
    pulse_clr();
    check("underrun_cleared", wr_if.underrun, 1'b0);

    // Slave 32-bit stereo following ws_in
    do_reset();
    write_word(32'hC0000003);
    write_word(32'h12345678);
    master = 1'b0; frame_size = 2'b10; stereo = 1'b1; standard = 1'b1; tx_en = 1'b1; ws_in = 1'b1;
    oe_acc = 1'b0;
    repeat (2) begin
      strobe(1'b0, 32'h0);
      oe_acc = oe_acc | ws_oe | s_ws;
    end
    check("sl_wait_idle", busy, 1'b0);
    ws_in = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) ws_in = 1'b1;
      strobe(1'b0, 32'h0);
      oe_acc = oe_acc | ws_oe | s_ws;
      if (i == 0) check("sl_msb_on_edge", {busy, s_sd}, 2'b11);
    end
    check("sl_left", v_sd[63:32], 32'hC0000003);
    check("sl_right", v_sd[31:0], 32'h12345678);
    check("sl_ws_oe_low", oe_acc, 1'b0);
    tx_en = 1'b0; ws_in = 1'b0;
    strobe(1'b0, 32'h0);
    check("sl_idle", {busy, wr_if.level}, 5'h0);

    // Reset in the middle of the right slot, with strobe and write active
    do_reset();
    write_word(32'hFFFF);
    write_word(32'hFFFF);
    master = 1'b1; frame_size = 2'b00; stereo = 1'b1; standard = 1'b1; tx_en = 1'b1;
    repeat (20) strobe(1'b0, 32'h0);
    check("pre_rst_right", {busy, ws_out, ws_oe, sd_out}, 4'hF);
    @(negedge wclk);
    rst = 1'b1; bit_en = 1'b1; wr_if.wen = 1'b1; wr_if.din = 32'h1234;
    @(negedge wclk);
    bit_en = 1'b0; wr_if.wen = 1'b0; tx_en = 1'b0;
    check("mid_frame_reset", {wr_if.full, wr_if.empty, wr_if.level, wr_if.overflow, wr_if.underrun,
                              sd_out, ws_out, ws_oe, busy}, 12'h400);
    rst = 1'b0;

    // Write and pop in the same cycle
    write_word(32'h8001);
    write_word(32'h0002);
    tx_en = 1'b1;
    strobe(1'b1, 32'h4000);
    check("push_pop_level", wr_if.level, 2);
    tx_en = 1'b0;
    for (int i = 0; i < 31; i++) strobe(1'b0, 32'h0);
    check("push_pop_sd", v_sd[31:0], 32'h80010002);
    strobe(1'b0, 32'h0);
    check("push_pop_end", {busy, wr_if.level}, 5'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
